// File: rtl/load_store_unit.sv
// Load/store unit sitting between the execute stage and a single-port memory.
// One operation at a time: accept, access memory (or flag an error), respond.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [4:0]  RdIn,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic [4:0]  RespRd,
    output logic [1:0]  RespErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;
    logic [31:0] resp_data_q;
    logic [1:0]  resp_err_q;

    logic        illegal_req;
    logic        misaligned_req;
    logic [7:0]  cnt_d;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] lane_word;
    logic [31:0] load_data;

    // Request checks look at the incoming operation so the error can be
    // registered at the accept edge.
    always_comb begin
        illegal_req    = 1'b0;
        misaligned_req = 1'b0;
        if (MemWrite) begin
            illegal_req = (Funct3 > 3'b010);
        end else begin
            illegal_req = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
        end
        case (Funct3)
            3'b001, 3'b101: misaligned_req = ALUResult[0];
            3'b010:         misaligned_req = |ALUResult[1:0];
            default:        misaligned_req = 1'b0;
        endcase
    end

    // Lane placement for stores and lane extraction for loads, from latched fields.
    always_comb begin
        cnt_d      = cnt_q + 8'd1;
        store_be   = 4'b1111;
        store_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_be   = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata_q;
            end
        endcase

        lane_word = MemRData >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_data = {24'h0, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = MemRData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ReqValid) begin
                        addr_q      <= ALUResult;
                        wdata_q     <= WriteData;
                        we_q        <= MemWrite;
                        funct3_q    <= Funct3;
                        rd_q        <= RdIn;
                        cnt_q       <= '0;
                        resp_data_q <= '0;
                        if (illegal_req) begin
                            resp_err_q <= ERR_ILLEGAL;
                            state_q    <= S_RESP;
                        end else if (misaligned_req) begin
                            resp_err_q <= ERR_MISALIGN;
                            state_q    <= S_RESP;
                        end else begin
                            resp_err_q <= ERR_OK;
                            state_q    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // An acknowledge in the last allowed cycle still completes normally.
                    if (MemAck) begin
                        resp_data_q <= we_q ? 32'h0 : load_data;
                        resp_err_q  <= ERR_OK;
                        state_q     <= S_RESP;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        resp_data_q <= '0;
                        resp_err_q  <= ERR_TIMEOUT;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; idle/response cycles drive zeros.
    assign ReqReady  = (state_q == S_IDLE);
    assign MemReq    = (state_q == S_WAIT);
    assign MemWe     = MemReq & we_q;
    assign MemAddr   = MemReq ? {addr_q[31:2], 2'b00} : 32'h0;
    assign MemByteEn = MemReq ? (we_q ? store_be : 4'b1111) : 4'b0000;
    assign MemWData  = (MemReq && we_q) ? store_data : 32'h0;
    assign RespValid = (state_q == S_RESP);
    assign RespData  = RespValid ? resp_data_q : 32'h0;
    assign RespRd    = RespValid ? rd_q : 5'h0;
    assign RespErr   = RespValid ? resp_err_q : ERR_OK;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, consecutive MemReq cycles without MemAck before a timeout error (legal range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 ReqValid  in  1  execute stage presents a memory operation.
REQ-005 ReqReady  out  1  unit can accept a request this cycle.
REQ-006 ALUResult  in  32  effective byte address computed by the ALU.
REQ-007 WriteData  in  32  store data (rs2).
REQ-008 MemWrite  in  1  1 = store, 0 = load.
REQ-009 Funct3  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 RdIn  in  5  destination register tag.
REQ-011 MemReq  out  1  memory request strobe.
REQ-012 MemWe  out  1  memory write enable.
REQ-013 MemAddr  out  32  word address, bits [1:0] forced to 00.
REQ-014 MemWData  out  32  lane-aligned store data.
REQ-015 MemByteEn  out  4  byte-lane enables.
REQ-016 MemAck  in  1  memory completion; read data valid in the same cycle.
REQ-017 MemRData  in  32  read word.
REQ-018 RespValid  out  1  single-cycle completion pulse.
REQ-019 RespData  out  32  extended load data; 0 for stores and errors.
REQ-020 RespRd  out  5  latched RdIn.
REQ-021 RespErr  out  2  00 ok, 01 misaligned, 10 illegal Funct3, 11 timeout.

Function
REQ-022 FSM states: IDLE, WAIT, RESP; ReqReady = 1 only in IDLE.
REQ-023 IDLE, ReqValid=1: latch ALUResult, WriteData, MemWrite, Funct3, RdIn in the same cycle.
REQ-024 Illegal Funct3 (loads 011/110/111; stores anything above 010): no memory access; next state RESP, RespErr=10.
REQ-025 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=00): no memory access; next state RESP, RespErr=01; illegal Funct3 takes priority.
REQ-026 Otherwise next state WAIT; MemReq=1 with MemAddr, MemWe, MemWData, MemByteEn held stable for every WAIT cycle.
REQ-027 Store lanes: SB enable = 0001 << addr[1:0], byte replicated 4x; SH enable 0011 (addr[1]=0) or 1100, halfword replicated 2x; SW enable 1111.
REQ-028 Loads: MemWe=0, MemByteEn=1111; select lane by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-029 WAIT with MemAck=1: capture extracted data (0 for stores), RespErr=00, next state RESP; MemReq deasserts the following cycle.
REQ-030 WAIT counter: counts consecutive cycles without MemAck; after TIMEOUT such cycles, next state RESP with RespErr=11; MemAck in that final cycle wins and returns ok.
REQ-031 RESP: RespValid=1 for exactly one cycle with RespData, RespRd and RespErr; next state IDLE unconditionally.
REQ-032 Minimum latency: accepted at edge k, MemReq high in cycle k+1; MemAck there gives RespValid in cycle k+2; error paths give RespValid in cycle k+1.
REQ-033 MemAck outside WAIT is ignored.
REQ-034 Outputs are registered or decoded from registered state only; no combinational path from ReqValid or MemAck to any output.

Reset
REQ-035 rst_n=0 at a rising edge: state IDLE, counter 0, all latched fields 0.
REQ-036 During and after reset: MemReq=0, MemWe=0, MemByteEn=0000, MemAddr=0, MemWData=0, RespValid=0, RespData=0, RespRd=0, RespErr=00; ReqReady=1 from the first cycle after rst_n returns to 1.
REQ-037 Reset in WAIT or RESP aborts the operation; MemReq and RespValid are low from the next cycle with no response emitted.

Verification
REQ-038 LB: addr 0x1003, MemRData 0x80FF_1234, MemAck in the first WAIT cycle -> MemAddr 0x1000, RespData 0xFFFF_FF80, RespErr 00, RespValid 2 cycles after accept.
REQ-039 LHU: addr 0x2002, MemRData 0x9ABC_0000 -> RespData 0x0000_9ABC; LH gives 0xFFFF_9ABC.
REQ-040 SB: addr 0x3001, WriteData 0x0000_00A5 -> MemByteEn 0010, MemWData 0xA5A5_A5A5, MemWe 1; SH at 0x3002 -> MemByteEn 1100.
REQ-041 LW: addr 0x4002 -> no MemReq, RespErr 01, RespValid the cycle after accept; store with Funct3 011 -> RespErr 10.
REQ-042 TIMEOUT=16, MemAck held 0 -> MemReq high exactly 16 cycles, then RespErr 11; repeat with MemAck in cycle 16 -> RespErr 00.
REQ-043 rst_n=0 in the 3rd WAIT cycle -> MemReq low next cycle, no RespValid, ReqReady=1 after release.
